// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response channel plus the
// decode-side valid/ready channel of the fetch queue.
// master = fetch_queue side, slave = memory/decode side.
interface fetch_queue_if;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_misalign;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output out_valid, out_inst, out_pc, out_misalign,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  out_valid, out_inst, out_pc, out_misalign,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction-fetch front end. Issues one memory
// request per accepted PC, tags responses with their PC, buffers them in a
// DEPTH-entry queue and hands them to decode. A flush empties the queue and
// marks every in-flight response for discard.
// Optional feature macro: FETCH_QUEUE_MISALIGN_EN (misaligned-PC fault entry).
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    input  logic        flush,
    output logic        stall,
    fetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [CW-1:0] occ_reg, outst_reg, drop_reg;
    logic          faulted_reg;
    logic [AW-1:0] tag_wr_reg, tag_rd_reg, q_wr_reg, q_rd_reg;

    logic [63:0] tag_mem  [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [63:0] pc_mem   [DEPTH];

    logic [CW:0]   used_sum;
    logic          credit, misaligned, fire, resp_take, resp_enq;
    logic          fault_enq, enq, pop, out_valid_w;
    logic [CW-1:0] outst_next;
    logic [31:0]   enq_inst;
    logic [63:0]   enq_pc;

    // Request/response/queue handshake decode
    always_comb begin
        used_sum    = {1'b0, occ_reg} + {1'b0, outst_reg};
        credit      = used_sum < DEPTH_W;
        bus.imem_req_valid = rst & ~flush & credit & ~faulted_reg & ~misaligned;
        bus.imem_req_addr  = pc;
        fire        = bus.imem_req_valid & bus.imem_req_ready;
        stall       = ~fire;
        // Responses with nothing outstanding belong to a pre-reset epoch
        resp_take   = rst & bus.imem_resp_valid & (outst_reg != '0);
        resp_enq    = resp_take & ~flush & (drop_reg == '0);
        // Fault entry waits until older responses have landed so order holds
        fault_enq   = rst & ~flush & ~faulted_reg & misaligned &
                      (outst_reg == '0) & (occ_reg != DEPTH_W[CW-1:0]);
        enq         = resp_enq | fault_enq;
        enq_inst    = fault_enq ? 32'h0000_0013 : bus.imem_resp_data;
        enq_pc      = fault_enq ? pc : tag_mem[tag_rd_reg];
        out_valid_w = rst & ~flush & (occ_reg != '0);
        pop         = out_valid_w & bus.out_ready;
        outst_next  = outst_reg + CW'(fire) - CW'(resp_take);
        bus.out_valid = out_valid_w;
        bus.out_inst  = inst_mem[q_rd_reg];
        bus.out_pc    = pc_mem[q_rd_reg];
    end

`ifdef FETCH_QUEUE_MISALIGN_EN
    logic mis_mem [DEPTH];

    assign misaligned = (pc[1:0] != 2'b00);

    // Misalign flag storage alongside each queue entry
    always_ff @(posedge clk) begin
        if (enq) begin
            mis_mem[q_wr_reg] <= fault_enq;
        end
    end

    assign bus.out_misalign = rst & mis_mem[q_rd_reg];
`else
    assign misaligned       = 1'b0;
    assign bus.out_misalign = 1'b0;
`endif

    // Tag FIFO and instruction queue storage (no reset needed on data)
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[tag_wr_reg] <= pc;
        end
        if (enq) begin
            inst_mem[q_wr_reg] <= enq_inst;
            pc_mem[q_wr_reg]   <= enq_pc;
        end
    end

    // Counters, pointers, drop accounting and fault latch
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_reg     <= '0;
            outst_reg   <= '0;
            drop_reg    <= '0;
            faulted_reg <= 1'b0;
            tag_wr_reg  <= '0;
            tag_rd_reg  <= '0;
            q_wr_reg    <= '0;
            q_rd_reg    <= '0;
        end else begin
            outst_reg  <= outst_next;
            tag_wr_reg <= tag_wr_reg + AW'(fire);
            tag_rd_reg <= tag_rd_reg + AW'(resp_take);
            if (flush) begin
                // Everything still in flight after this edge is wrong-path
                occ_reg     <= '0;
                q_wr_reg    <= '0;
                q_rd_reg    <= '0;
                drop_reg    <= outst_next;
                faulted_reg <= 1'b0;
            end else begin
                occ_reg  <= occ_reg + CW'(enq) - CW'(pop);
                q_wr_reg <= q_wr_reg + AW'(enq);
                q_rd_reg <= q_rd_reg + AW'(pop);
                if (resp_take && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CW'(1);
                end
                if (fault_enq) begin
                    faulted_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a latency-programmable
// memory model, a PC-register model and a scoreboard of expected decode
// entries filled on request fire and drained on each decode pop.
module tb_fetch_queue;
    typedef struct packed {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pc = 64'h0;
    logic        flush = 1'b0;
    logic        stall;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .pc   (pc),
        .flush(flush),
        .stall(stall),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_fire = 0;
    int          n_pop = 0;
    int          base;
    logic [63:0] jump_target = 64'h0;
    logic [63:0] last_fire_addr = 64'h0;
    logic [63:0] first_pc = 64'h0;
    logic [63:0] held;
    bit          want_first = 1'b0;
    mreq_t       mem[$];
    exp_t        sb[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample the settled cycle, advance, update models
    task automatic step();
        logic        f, p, st, fl;
        logic [63:0] a;
        exp_t        e;
        #1;
        f  = bus.imem_req_valid & bus.imem_req_ready;
        a  = bus.imem_req_addr;
        p  = bus.out_valid & bus.out_ready;
        st = stall;
        fl = flush;
        if (p) begin
            check("sb_nonempty_on_pop", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_pc", bus.out_pc, e.pc);
                check("out_inst", 64'(bus.out_inst), 64'(e.inst));
                check("out_misalign", 64'(bus.out_misalign), 64'(e.mis));
            end
            if (want_first) begin
                first_pc   = bus.out_pc;
                want_first = 1'b0;
            end
            n_pop++;
            $display("cyc %0d pop  pc=%h inst=%h mis=%0b", cyc, bus.out_pc, bus.out_inst, bus.out_misalign);
        end
        if (bus.imem_resp_valid && mem.size() != 0) mem.delete(0);
        if (f) begin
            mem.push_back('{addr: a, due: cyc + lat});
            sb.push_back('{pc: a, inst: inst_of(a), mis: 1'b0});
            last_fire_addr = a;
            n_fire++;
            $display("cyc %0d fire addr=%h", cyc, a);
        end
        if (fl) sb.delete();
        @(posedge clk);
        #1;
        cyc++;
        if (fl) pc = jump_target;
        else if (!st) pc = pc + 64'd4;
        flush = 1'b0;
        bus.imem_resp_valid = (mem.size() != 0) && (mem[0].due <= cyc);
        bus.imem_resp_data  = bus.imem_resp_valid ? inst_of(mem[0].addr) : 32'h0;
        #1;
    endtask

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.out_ready       = 1'b0;

        // Reset behaviour
        step(); step();
        check("rst_stall", 64'(stall), 64'd1);
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_misalign", 64'(bus.out_misalign), 64'd0);

        // Back-to-back fetch from pc 0 with 1-cycle memory
        rst = 1'b1; pc = 64'h0; lat = 1;
        bus.imem_req_ready = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("b2b_stall", 64'(stall), 64'd0);
            check("b2b_addr", bus.imem_req_addr, 64'(4 * i));
            step();
        end
        bus.imem_req_ready = 1'b0;
        repeat (4) step();
        check("b2b_pops", 64'(n_pop), 64'd3);
        check("b2b_sb_empty", 64'(sb.size()), 64'd0);

        // Credit limit with decode blocked
        bus.imem_req_ready = 1'b1; bus.out_ready = 1'b0;
        base = n_fire;
        repeat (10) step();
        check("full_fires", 64'(n_fire - base), 64'd4);
        check("full_stall", 64'(stall), 64'd1);
        check("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        base = n_fire;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        repeat (5) step();
        check("one_pop_one_fire", 64'(n_fire - base), 64'd1);
        bus.imem_req_ready = 1'b0; bus.out_ready = 1'b1;
        repeat (8) step();
        check("full_drain_empty", 64'(sb.size()), 64'd0);

        // Flush with two 3-cycle responses in flight
        lat = 3; bus.imem_req_ready = 1'b1;
        base = n_fire;
        step(); step();
        check("lat3_two_out", 64'(n_fire - base), 64'd2);
        flush = 1'b1; jump_target = 64'h100;
        #1;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_req_valid", 64'(bus.imem_req_valid), 64'd0);
        want_first = 1'b1;
        step();
        repeat (10) step();
        check("after_flush_first_pc", first_pc, 64'h100);
        bus.imem_req_ready = 1'b0;
        repeat (8) step();
        check("lat3_drain_empty", 64'(sb.size()), 64'd0);

        // Memory not ready for 5 cycles: PC held
        lat = 1;
        held = pc;
        for (int i = 0; i < 5; i++) begin
            check("notready_stall", 64'(stall), 64'd1);
            check("notready_addr", bus.imem_req_addr, held);
            step();
        end
        bus.imem_req_ready = 1'b1;
        #1;
        check("ready_stall", 64'(stall), 64'd0);
        base = n_fire;
        step();
        check("ready_fire", 64'(n_fire - base), 64'd1);
        check("ready_fire_addr", last_fire_addr, held);
        bus.imem_req_ready = 1'b0;
        repeat (4) step();

        // Flush coinciding with a response and a ready decode
        bus.out_ready = 1'b0; bus.imem_req_ready = 1'b1;
        step(); step();
        bus.imem_req_ready = 1'b0;
        check("coinc_resp_present", 64'(bus.imem_resp_valid), 64'd1);
        bus.out_ready = 1'b1;
        flush = 1'b1; jump_target = 64'h200;
        #1;
        check("coinc_out_valid", 64'(bus.out_valid), 64'd0);
        step();
        check("coinc_occ_zero", 64'(bus.out_valid), 64'd0);
        step(); step();
        check("coinc_no_enq", 64'(bus.out_valid), 64'd0);
        want_first = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (6) step();
        bus.imem_req_ready = 1'b0;
        repeat (6) step();
        check("coinc_first_pc", first_pc, 64'h200);
        check("coinc_sb_empty", 64'(sb.size()), 64'd0);

`ifdef FETCH_QUEUE_MISALIGN_EN
        // Misaligned jump produces a single fault entry and locks fetch
        bus.imem_req_ready = 1'b1; bus.out_ready = 1'b0;
        flush = 1'b1; jump_target = 64'h102;
        step();
        sb.push_back('{pc: 64'h102, inst: 32'h0000_0013, mis: 1'b1});
        check("mis_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("mis_stall", 64'(stall), 64'd1);
        step();
        check("mis_out_valid", 64'(bus.out_valid), 64'd1);
        check("mis_flag", 64'(bus.out_misalign), 64'd1);
        base = n_fire;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mis_locked_stall", 64'(stall), 64'd1);
        end
        check("mis_no_fire", 64'(n_fire - base), 64'd0);
        check("mis_single_entry", 64'(bus.out_valid), 64'd0);
        flush = 1'b1; jump_target = 64'h300;
        step();
        base = n_fire;
        step();
        check("mis_recover_fire", 64'(n_fire - base), 64'd1);
        check("mis_recover_addr", last_fire_addr, 64'h300);
        bus.imem_req_ready = 1'b0;
        repeat (6) step();
        check("mis_sb_empty", 64'(sb.size()), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
